// File: rtl/rom_burst_arbiter_pkg.sv
// Shared constants, FSM encoding and burst-length helper for the ROM burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_burst_arbiter_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_t;

    // Number of words in a burst for a given length code (code 0 = 1 word, 31 = 32 words).
    function automatic logic [ADDR_W:0] burst_len(input logic [ADDR_W-1:0] code);
        return {1'b0, code} + (ADDR_W+1)'(1);
    endfunction

endpackage

// File: rtl/rom_burst_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select with a priority pointer register.
// Latency: winner is combinational; pointer updates on the edge where iUpdEn is high.
// Backpressure: none; the caller decides when a grant is taken and when to advance.
module rr_arbiter2 (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [1:0] iReq,
    input  logic       iUpdEn,
    input  logic       iServed,
    output logic       oWinner
);

    logic r_ptr;

    // Pointer requester wins if it is asking, otherwise the other one.
    always_comb begin
        oWinner = r_ptr;
        if (!iReq[r_ptr]) begin
            oWinner = ~r_ptr;
        end
    end

    // After a burst completes, the requester that was not served gets priority.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_ptr <= 1'b0;
        end else if (iUpdEn) begin
            r_ptr <= ~iServed;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares a synchronous-read 32x8 ROM between two burst requesters, round-robin.
// Latency: request sampled at E0, first oValid in the cycle after E1, one word per cycle.
// Backpressure: none on the data side; requesters hold iReq/iAddr/iLen until oGnt.
module rom_burst_arbiter
    import rom_burst_arbiter_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [1:0]        iReq,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iLen0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [ADDR_W-1:0] iLen1,
    output logic [1:0]        oGnt,
    output logic [ADDR_W-1:0] oRomAddr,
    input  logic [DATA_W-1:0] iRomData,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic [1:0]        oDone
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_gnt;
    logic [1:0]        w_gnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [1:0]        r_done;
    logic [1:0]        w_done_nxt;
    logic              w_ptr_upd;
    logic              w_win;

    rr_arbiter2 u_arb (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iReq    (iReq),
        .iUpdEn  (w_ptr_upd),
        .iServed (r_gnt[1]),
        .oWinner (w_win)
    );

    // State register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register values. READ always spends at least one edge
    // (even for a 1-word burst) so the ROM's one-cycle read latency lines up with oValid;
    // on the cnt==0 edge the last address is already out, so the address is held.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 2'b00;
        w_ptr_upd   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_gnt_nxt = 2'b00;
                if (|iReq) begin
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_addr_nxt  = w_win ? iAddr1 : iAddr0;
                    w_cnt_nxt   = w_win ? iLen1 : iLen0;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_valid_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_done_nxt  = r_gnt;
                    w_state_nxt = LAST;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_cnt_nxt  = r_cnt - ADDR_W'(1);
                end
            end
            LAST: begin
                w_gnt_nxt   = 2'b00;
                w_ptr_upd   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: grant, ROM address, remaining count, valid and done strobes.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_gnt   <= 2'b00;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 2'b00;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign oGnt     = r_gnt;
    assign oRomAddr = r_addr;
    assign oValid   = r_valid;
    assign oDone    = r_done;
    assign oData    = iRomData;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter with a behavioural synchronous ROM.
// Latency: expectations queued at stimulus time, popped by a monitor on each oValid.
// Backpressure: n/a.
module tb_rom_burst_arbiter;
    import rom_burst_arbiter_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [1:0]        done;
        logic [1:0]        gnt;
    } exp_t;

    logic              iClk = 1'b0;
    logic              iRst_n;
    logic [1:0]        iReq;
    logic [ADDR_W-1:0] iAddr0, iLen0, iAddr1, iLen1;
    logic [1:0]        oGnt;
    logic [ADDR_W-1:0] oRomAddr;
    logic [DATA_W-1:0] iRomData;
    logic [DATA_W-1:0] oData;
    logic              oValid;
    logic [1:0]        oDone;

    logic [DATA_W-1:0] rom [32];
    exp_t              exp_q [$];
    exp_t              mon_e;
    int                n_checks = 0;
    int                n_fail   = 0;

    rom_burst_arbiter dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iReq     (iReq),
        .iAddr0   (iAddr0),
        .iLen0    (iLen0),
        .iAddr1   (iAddr1),
        .iLen1    (iLen1),
        .oGnt     (oGnt),
        .oRomAddr (oRomAddr),
        .iRomData (iRomData),
        .oData    (oData),
        .oValid   (oValid),
        .oDone    (oDone)
    );

    always #5 iClk = ~iClk;

    // Synchronous-read ROM, one cycle latency.
    always @(posedge iClk) iRomData <= rom[oRomAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid word must match the head of the queue.
    always @(negedge iClk) begin
        if (iRst_n === 1'b1) begin
            if (oValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data %0h with empty queue at %0t", oData, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", 32'(oData), 32'(mon_e.dat));
                    check("done", 32'(oDone), 32'(mon_e.done));
                    check("gnt_during_valid", 32'(oGnt), 32'(mon_e.gnt));
                end
            end else begin
                check("done_without_valid", 32'(oDone), 32'd0);
            end
        end
    end

    task automatic push_burst(input logic [1:0] g, input logic [ADDR_W-1:0] a,
                              input logic [ADDR_W-1:0] l);
        int   n;
        exp_t e;
        logic [ADDR_W-1:0] ad;
        n = int'(burst_len(l));
        for (int k = 0; k < n; k++) begin
            ad    = a + ADDR_W'(k);
            e.dat = rom[ad];
            e.done = (k == n - 1) ? g : 2'b00;
            e.gnt = g;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string name);
        bit found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge iClk);
            if (oGnt != 2'b00) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no grant within 100 cycles, expected %0h", name, g);
        end else begin
            check(name, 32'(oGnt), 32'(g));
        end
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge iClk);
            if (oDone != 2'b00) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no oDone within 100 cycles, got oGnt %0h", name, oGnt);
        end else begin
            @(negedge iClk);
            check({name, "_gnt_drop"}, 32'(oGnt), 32'd0);
            check({name, "_valid_drop"}, 32'(oValid), 32'd0);
        end
    endtask

    task automatic run_burst(input logic [1:0] g, input logic [ADDR_W-1:0] a,
                             input logic [ADDR_W-1:0] l, input string name);
        if (g == 2'b10) begin
            iAddr1 = a;
            iLen1  = l;
        end else begin
            iAddr0 = a;
            iLen0  = l;
        end
        push_burst(g, a, l);
        iReq = g;
        wait_gnt(g, {name, "_grant"});
        iReq = 2'b00;
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        logic [1:0]  g;
        for (int i = 0; i < 32; i++) rom[i] = DATA_W'(i * 37 + 11);
        iRst_n = 1'b0;
        iReq   = 2'b00;
        iAddr0 = '0;
        iLen0  = '0;
        iAddr1 = '0;
        iLen1  = '0;

        // Reset values.
        #1;
        check("rst_gnt", 32'(oGnt), 32'd0);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_addr", 32'(oRomAddr), 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        repeat (2) @(negedge iClk);
        check("idle_gnt", 32'(oGnt), 32'd0);
        check("idle_valid", 32'(oValid), 32'd0);

        // Both request right after reset, 1-word bursts: 0 first, one idle cycle, then 1.
        iAddr0 = 5'd5;
        iLen0  = 5'd0;
        iAddr1 = 5'd9;
        iLen1  = 5'd0;
        push_burst(2'b01, 5'd5, 5'd0);
        push_burst(2'b10, 5'd9, 5'd0);
        iReq = 2'b11;
        wait_gnt(2'b01, "rr_first_grant");
        @(negedge iClk);
        check("rr_hold", 32'(oGnt), 32'h1);
        @(negedge iClk);
        check("rr_gap", 32'(oGnt), 32'h0);
        @(negedge iClk);
        check("rr_second_grant", 32'(oGnt), 32'h2);
        iReq = 2'b00;
        wait_done("rr_second");

        // Requester 0, 4 words from address 3.
        run_burst(2'b01, 5'd3, 5'd3, "req0_len4");
        check("req0_last_addr", 32'(oRomAddr), 32'd6);

        // Requester 1, wrap 30,31,0,1; address held in idle.
        run_burst(2'b10, 5'd30, 5'd3, "req1_wrap");
        @(negedge iClk);
        check("idle_addr_hold", 32'(oRomAddr), 32'd1);

        // Both held for 4 bursts; addresses changed after each grant.
        iAddr0 = 5'd10;
        iLen0  = 5'd1;
        iAddr1 = 5'd20;
        iLen1  = 5'd2;
        iReq   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(g, "fair_grant");
            if (g == 2'b01) begin
                push_burst(2'b01, iAddr0, iLen0);
                iAddr0 = iAddr0 + 5'd2;
            end else begin
                push_burst(2'b10, iAddr1, iLen1);
                iAddr1 = iAddr1 + 5'd5;
            end
            if (k == 3) iReq = 2'b00;
            wait_done("fair");
        end

        // Full 32-word burst.
        run_burst(2'b01, 5'd0, 5'd31, "req0_len32");

        // Reset during the 3rd word of a requester-1 burst.
        iAddr1 = 5'd8;
        iLen1  = 5'd7;
        push_burst(2'b10, 5'd8, 5'd7);
        iReq = 2'b10;
        wait_gnt(2'b10, "abort_grant");
        iReq = 2'b00;
        nv = 0;
        for (int k = 0; k < 50 && nv < 3; k++) begin
            @(negedge iClk);
            if (oValid) nv++;
        end
        #1;
        iRst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(oGnt), 32'd0);
        check("abort_valid", 32'(oValid), 32'd0);
        check("abort_done", 32'(oDone), 32'd0);
        check("abort_addr", 32'(oRomAddr), 32'd0);
        check("abort_words_seen", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;

        // Pointer was 1 before reset; after reset requester 0 must win first.
        iAddr0 = 5'd17;
        iLen0  = 5'd0;
        iAddr1 = 5'd2;
        iLen1  = 5'd0;
        push_burst(2'b01, 5'd17, 5'd0);
        push_burst(2'b10, 5'd2, 5'd0);
        iReq = 2'b11;
        wait_gnt(2'b01, "post_rst_grant0");
        wait_done("post_rst_0");
        wait_gnt(2'b10, "post_rst_grant1");
        iReq = 2'b00;
        wait_done("post_rst_1");

        repeat (5) @(negedge iClk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
